// File: rtl/fetch_queue.sv
// In-order fetch buffer: accepts instruction pairs from the loader and issues them
// to the decoder through two valid/ready slots, with registered back-pressure.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          address_in [2],
  input  logic [31:0]              instr_in   [2],
  output logic                     stop,
  output logic [1:0]               out_valid,
  input  logic [1:0]               out_ready,
  output logic [XLEN-1:0]          address_out [2],
  output logic [31:0]              instr_out   [2],
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_addr  [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_nxt1;

  logic            deq0;
  logic            deq1;
  logic [1:0]      deq;
  logic [CW:0]     room_need;
  logic            accept;
  logic [CW-1:0]   count_next;

  assign head_nxt1    = head + PW'(1);
  assign out_valid[0] = (count >= CW'(1));
  assign out_valid[1] = (count >= CW'(2));

  assign address_out[0] = mem_addr[head];
  assign address_out[1] = mem_addr[head_nxt1];
  assign instr_out[0]   = mem_instr[head];
  assign instr_out[1]   = mem_instr[head_nxt1];

  // Slot 1 only retires together with slot 0, keeping issue in program order.
  assign deq0 = out_valid[0] & out_ready[0];
  assign deq1 = deq0 & out_valid[1] & out_ready[1];
  assign deq  = {1'b0, deq0} + {1'b0, deq1};

  // One extra bit so count - deq + 2 cannot wrap when the queue is full.
  assign room_need  = {1'b0, count} - (CW+1)'(deq) + (CW+1)'(2);
  assign accept     = in_valid & (room_need <= (CW+1)'(DEPTH));
  assign count_next = count + (accept ? CW'(2) : CW'(0)) - CW'(deq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      stop     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i]  <= '0;
        mem_instr[i] <= '0;
      end
    end else begin
      if (in_valid && !accept && !flush) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        stop  <= 1'b0;
      end else begin
        head  <= head + PW'(deq);
        count <= count_next;
        // Threshold leaves room for the one pair the loader has in flight.
        stop  <= (count_next > CW'(DEPTH - 4));
        if (accept) begin
          mem_addr[tail]             <= address_in[0];
          mem_instr[tail]            <= instr_in[0];
          mem_addr[tail + PW'(1)]    <= address_in[1];
          mem_instr[tail + PW'(1)]   <= instr_in[1];
          tail                       <= tail + PW'(2);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=8): fill/stop, overflow, ordered drain,
// wrap with ready patterns, count=7 corner cases, async reset and flush.
module tb_fetch_queue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] address_in [2];
  logic [31:0] instr_in   [2];
  logic        stop;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [31:0] address_out [2];
  logic [31:0] instr_out   [2];
  logic [3:0]  count;
  logic        overflow;
  logic        run;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .address_in(address_in), .instr_in(instr_in), .stop(stop),
    .out_valid(out_valid), .out_ready(out_ready), .address_out(address_out),
    .instr_out(instr_out), .count(count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic v, input logic [31:0] a0, input logic [31:0] i0,
                          input logic [31:0] i1);
    in_valid      = v;
    address_in[0] = a0;
    address_in[1] = a0 + 32'd4;
    instr_in[0]   = i0;
    instr_in[1]   = i1;
  endtask

  initial begin
    logic [1:0]  pat [4];
    logic [1:0]  v;
    logic [1:0]  r;
    logic        d0;
    logic        d1;
    int          sent;
    int          ret;
    int          cyc;
    int          prev_count;
    int          exp_count;
    logic        sent_now;

    run       = 1'b0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 2'b00;
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);

    // Reset without any clock edge.
    #2;
    chk("rst_count", count, 0);
    chk("rst_stop", stop, 0);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_instr0", instr_out[0], 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    #1 run = 1'b1;
    tick();

    // Fill with four back-to-back pairs, decoder stalled.
    set_pair(1'b1, 32'h200, 32'h11, 32'h12); tick();
    chk("fill1_count", count, 2); chk("fill1_stop", stop, 0);
    set_pair(1'b1, 32'h208, 32'h13, 32'h14); tick();
    chk("fill2_count", count, 4); chk("fill2_stop", stop, 0);
    set_pair(1'b1, 32'h210, 32'h15, 32'h16); tick();
    chk("fill3_count", count, 6); chk("fill3_stop", stop, 1);
    set_pair(1'b1, 32'h218, 32'h17, 32'h18); tick();
    chk("fill4_count", count, 8); chk("fill4_stop", stop, 1);
    chk("fill4_overflow", overflow, 0);

    // Fifth pair into a full queue is dropped.
    set_pair(1'b1, 32'h220, 32'hEE, 32'hEF); tick();
    chk("drop_count", count, 8);
    chk("drop_overflow", overflow, 1);
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    chk("full_out_valid", out_valid, 2'b11);

    out_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      chk("drain_i0", instr_out[0], 32'h11 + 2 * k);
      chk("drain_i1", instr_out[1], 32'h12 + 2 * k);
      chk("drain_a0", address_out[0], 32'h200 + 8 * k);
      tick();
    end
    out_ready = 2'b00;
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 2'b00);
    chk("drain_stop", stop, 0);

    // Ordered stream of 20 instructions across pointer wrap.
    pat[0] = 2'b11; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b00;
    sent = 0; ret = 0; cyc = 0;
    while (ret < 20 && cyc < 300) begin
      sent_now = (sent < 20) && !stop;
      set_pair(sent_now, 32'h100 + 4 * sent, 32'hA5000100 + 4 * sent,
               32'hA5000104 + 4 * sent);
      r = pat[cyc % 4];
      out_ready = r;
      v  = out_valid;
      d0 = v[0] & r[0];
      d1 = d0 & v[1] & r[1];
      if (d0) begin
        chk("wrap_a0", address_out[0], 32'h100 + 4 * ret);
        chk("wrap_i0", instr_out[0], 32'hA5000100 + 4 * ret);
      end
      if (d1) chk("wrap_a1", address_out[1], 32'h104 + 4 * ret);
      if (v[1]) chk("wrap_a1_seq", address_out[1], address_out[0] + 32'd4);
      prev_count = count;
      exp_count  = prev_count + (sent_now ? 2 : 0) - (d0 ? 1 : 0) - (d1 ? 1 : 0);
      tick();
      if (r == 2'b10) chk("wrap_pat10_noretire", count, prev_count + (sent_now ? 2 : 0));
      else chk("wrap_count", count, exp_count);
      if (sent_now) sent += 2;
      ret += (d0 ? 1 : 0) + (d1 ? 1 : 0);
      cyc++;
    end
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 2'b00;
    chk("wrap_retired", ret, 20);
    chk("wrap_overflow", overflow, 1);

    // Asynchronous reset mid-operation, between clock edges.
    set_pair(1'b1, 32'h300, 32'h21, 32'h22); tick();
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    chk("pre_rst_count", count, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 2'b00);
    chk("arst_addr0", address_out[0], 0);
    chk("arst_overflow", overflow, 0);
    #1 reset_n = 1'b1;
    tick();

    // Build count=7.
    set_pair(1'b1, 32'h400, 32'h31, 32'h32); tick();
    set_pair(1'b1, 32'h408, 32'h33, 32'h34); tick();
    set_pair(1'b1, 32'h410, 32'h35, 32'h36); tick();
    set_pair(1'b1, 32'h418, 32'h37, 32'h38); tick();
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 2'b01; tick();
    chk("c7_count", count, 7);
    chk("c7_i0", instr_out[0], 32'h32);

    set_pair(1'b1, 32'h500, 32'h41, 32'h42);
    out_ready = 2'b11; tick();
    chk("c7_accept_count", count, 7);
    chk("c7_accept_overflow", overflow, 0);
    chk("c7_accept_i0", instr_out[0], 32'h34);

    set_pair(1'b1, 32'h600, 32'h51, 32'h52);
    out_ready = 2'b00; tick();
    chk("c7_drop_count", count, 7);
    chk("c7_drop_overflow", overflow, 1);
    chk("c7_stop", stop, 1);

    // Flush at count=5 with a same-cycle pair.
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 2'b01; tick(); tick();
    out_ready = 2'b00;
    chk("f5_count", count, 5);
    flush = 1'b1;
    set_pair(1'b1, 32'h680, 32'h61, 32'h62);
    out_ready = 2'b11; tick();
    flush = 1'b0;
    out_ready = 2'b00;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 2'b00);
    chk("flush_stop", stop, 0);
    chk("flush_overflow_sticky", overflow, 1);

    set_pair(1'b1, 32'h700, 32'h71, 32'h72); tick();
    set_pair(1'b0, 32'h0, 32'h0, 32'h0);
    chk("post_flush_valid", out_valid, 2'b11);
    chk("post_flush_i0", instr_out[0], 32'h71);
    chk("post_flush_i1", instr_out[1], 32'h72);
    chk("post_flush_a0", address_out[0], 32'h700);
    chk("post_flush_count", count, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch buffer that sits directly downstream of the cache loader stage.
- Accepts up to one aligned instruction pair (two address/instruction words) per cycle from the loader and holds them in a circular FIFO.
- Issues them in program order to the decoder through two per-slot valid/ready ports.
- Back-pressures the loader with a registered stop signal sized to absorb the loader's one pair still in flight.

Parameters:
- XLEN, 32, address width.
- DEPTH, 8, queue capacity in instructions. Power of two, minimum 4.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous pipeline flush (delete_tagged/mispredict); clears the queue.
- in_valid  input  1  pair valid; both address_in and instr_in slots are meaningful.
- address_in[2]  input  XLEN each  addresses; slot 0 is older.
- instr_in[2]  input  32 each  instruction words.
- stop  output  1  registered back-pressure to the loader.
- out_valid  output  2  out_valid[i] means slot i holds an instruction.
- out_ready  input  2  decoder accepts slot i.
- address_out[2]  output  XLEN each  head and head+1 addresses.
- instr_out[2]  output  32 each  head and head+1 instructions.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky error: a pair was dropped.

Behaviour:
- Reset (reset_n low, asynchronous):
  - head, tail and count = 0; stop = 0; overflow = 0.
  - Storage is cleared to 0, so address_out/instr_out = 0 and out_valid = 2'b00.
- Output side (combinational from registers):
  - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
  - Slot 0 reads mem[head]; slot 1 reads mem[(head+1) mod DEPTH].
- Dequeue, in order:
  - deq0 = out_valid[0] & out_ready[0].
  - deq1 = deq0 & out_valid[1] & out_ready[1]. Slot 1 never retires without slot 0.
  - deq = deq0 + deq1, range 0..2.
  - head advances by deq mod DEPTH.
- Enqueue:
  - A pair is accepted iff in_valid & (count - deq + 2 <= DEPTH). Same-cycle dequeue frees space.
  - On accept: mem[tail] = slot 0, mem[(tail+1) mod DEPTH] = slot 1, and tail advances by 2 mod DEPTH.
  - If in_valid and space is insufficient: the pair is dropped, nothing is written, and overflow is set.
  - overflow stays set until reset; flush does not clear it.
- Count arithmetic:
  - count_next = count + 2·accept - deq, computed at width $clog2(DEPTH)+1.
  - count never exceeds DEPTH or goes below 0.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- stop (registered):
  - stop <= (count_next > DEPTH-4), forced to 0 on flush.
  - The loader samples stop at the clock edge and then presents at most one more pair. With this threshold, a conforming loader never causes overflow.
- Flush:
  - Takes priority over same-cycle enqueue and dequeue.
  - Next cycle: head = tail = count = 0, out_valid = 0, stop = 0.
  - Storage contents need not be cleared.
- Latency: a pair accepted at edge t is visible on the output ports in cycle t+1 (one cycle).
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.

Test Plan:
- Reset with reset_n low and no clock edge -> count=0, stop=0, out_valid=00, instr_out[0]=0, overflow=0.
- DEPTH=8, out_ready=00, four back-to-back pairs (instr 0x11..0x18):
  - count steps 2, 4, 6, 8.
  - stop rises after the count-6 edge; the fourth (in-flight) pair is accepted.
  - overflow stays 0.
- With the queue full, force a fifth in_valid -> pair dropped, count stays 8, overflow=1.
  - A subsequent drain still returns 0x11..0x18 in order.
- Order and wrap:
  - Sequence the addresses 0x100, 0x104, ... through a 20-instruction stream with out_ready patterns 11, 01, 10, 00.
  - Required response: slot 1 never retires when slot 0 is not ready (pattern 10 retires nothing), and the output address sequence is strictly +4 across pointer wrap.
- Simultaneous events at count=7 (DEPTH=8):
  - in_valid=1 with out_ready=11 -> accepted, count=7.
  - At count=7 with out_ready=00 -> pair dropped, overflow=1.
- Flush with count=5 and same-cycle in_valid=1 -> next cycle count=0, out_valid=00, stop=0.
  - The next pair appears on slot 0/1 after one cycle.
